// File: rtl/qpu_pkg.sv
// Shared widths, decode-info group field and the dispatch payload layout.
package qpu_pkg;
  localparam int XLEN         = 32;
  localparam int RFIDX_W      = 5;
  localparam int DECINFO_W    = 16;
  localparam int PC_W         = 32;
  localparam int TIME_W       = 32;
  localparam int QUBIT_NUM    = 4;
  localparam int EVENT_WIRE_W = 66;
  localparam int EVENT_NUM    = 8;
  localparam int TQGL_W       = 48;

  // Instruction group lives in the low bits of the decode info word
  localparam int GRP_LSB = 0;
  localparam int GRP_W   = 3;

  typedef enum logic [GRP_W-1:0] {
    GRP_ALU = 3'd0,
    GRP_LSU = 3'd1,
    GRP_BJP = 3'd2,
    GRP_QIU = 3'd3,
    GRP_MUL = 3'd4
  } grp_e;

  // Everything handed to the ALU stage, captured together on dispatch
  typedef struct packed {
    logic                    longpipe;
    logic [XLEN-1:0]         rs1;
    logic [XLEN-1:0]         rs2;
    logic                    rdwen;
    logic [RFIDX_W-1:0]      rdidx;
    logic [DECINFO_W-1:0]    info;
    logic [XLEN-1:0]         imm;
    logic [PC_W-1:0]         pc;
    logic [TIME_W-1:0]       clk;
    logic [QUBIT_NUM-1:0]    qmr;
    logic [EVENT_WIRE_W-1:0] edata;
    logic [EVENT_NUM-1:0]    oprand;
    logic [TQGL_W-1:0]       tqgl_pre;
    logic [TQGL_W-1:0]       tqgl_cur;
    logic                    ntp;
    logic                    fmr;
    logic                    measure;
  } alu_pld_t;

  function automatic logic is_grp(input logic [DECINFO_W-1:0] info, input grp_e g);
    return info[GRP_LSB +: GRP_W] == g;
  endfunction
endpackage

// File: rtl/qpu_gnrl_dfflr.sv
// Load-enable register with asynchronous active-low reset to zero.
module qpu_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_lden,
  input  logic [DW-1:0] i_dnxt,
  output logic [DW-1:0] o_qout
);
  logic [DW-1:0] r_q;

  // Capture on load enable, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_lden) r_q <= i_dnxt;
  end

  assign o_qout = r_q;
endmodule

// File: rtl/qpu_exu_dispatch.sv
// Dispatch stage: hazard/resource gating, OITF allocation and a one-entry
// registered slot feeding the ALU.
module qpu_exu_dispatch
  import qpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_i_valid,
  output logic                    disp_i_ready,
  input  logic                    disp_i_rs1x0,
  input  logic                    disp_i_rs2x0,
  input  logic                    disp_i_rs1en,
  input  logic                    disp_i_rs2en,
  input  logic                    disp_i_rdwen,
  input  logic                    disp_i_ntp,
  input  logic                    disp_i_measure,
  input  logic                    disp_i_nqf,
  input  logic                    disp_i_fmr,
  input  logic [RFIDX_W-1:0]      disp_i_rs1idx,
  input  logic [RFIDX_W-1:0]      disp_i_rs2idx,
  input  logic [RFIDX_W-1:0]      disp_i_rdidx,
  input  logic [XLEN-1:0]         disp_i_rs1,
  input  logic [XLEN-1:0]         disp_i_rs2,
  input  logic [XLEN-1:0]         disp_i_imm,
  input  logic [DECINFO_W-1:0]    disp_i_info,
  input  logic [PC_W-1:0]         disp_i_pc,
  input  logic [TIME_W-1:0]       disp_i_clk,
  input  logic [QUBIT_NUM-1:0]    disp_i_qmr,
  input  logic [EVENT_WIRE_W-1:0] disp_i_edata,
  input  logic [EVENT_NUM-1:0]    disp_i_oprand,
  input  logic [TQGL_W-1:0]       disp_i_tqgl_pre,
  input  logic [TQGL_W-1:0]       disp_i_tqgl_cur,
  output logic                    disp_o_alu_valid,
  input  logic                    disp_o_alu_ready,
  output logic                    disp_o_alu_longpipe,
  output logic [XLEN-1:0]         disp_o_alu_rs1,
  output logic [XLEN-1:0]         disp_o_alu_rs2,
  output logic                    disp_o_alu_rdwen,
  output logic [RFIDX_W-1:0]      disp_o_alu_rdidx,
  output logic [DECINFO_W-1:0]    disp_o_alu_info,
  output logic [XLEN-1:0]         disp_o_alu_imm,
  output logic [PC_W-1:0]         disp_o_alu_pc,
  output logic [TIME_W-1:0]       disp_o_alu_clk,
  output logic [QUBIT_NUM-1:0]    disp_o_alu_qmr,
  output logic [EVENT_WIRE_W-1:0] disp_o_alu_edata,
  output logic [EVENT_NUM-1:0]    disp_o_alu_oprand,
  output logic [TQGL_W-1:0]       disp_o_alu_tqgl_pre,
  output logic [TQGL_W-1:0]       disp_o_alu_tqgl_cur,
  output logic                    disp_o_alu_ntp,
  output logic                    disp_o_alu_fmr,
  output logic                    disp_o_alu_measure,
  input  logic                    oitfrd_match_disprs1,
  input  logic                    oitfrd_match_disprs2,
  input  logic                    oitfrd_match_disprd,
  input  logic                    oitfqf_match_dispql,
  output logic                    disp_oitf_ena,
  output logic                    disp_moitf_ena,
  input  logic                    disp_oitf_ready,
  input  logic                    disp_moitf_ready,
  output logic                    disp_oitf_rs1en,
  output logic                    disp_oitf_rs2en,
  output logic                    disp_oitf_rdwen,
  output logic                    disp_oitf_qfren,
  output logic [RFIDX_W-1:0]      disp_oitf_rs1idx,
  output logic [RFIDX_W-1:0]      disp_oitf_rs2idx,
  output logic [RFIDX_W-1:0]      disp_oitf_rdidx,
  output logic [QUBIT_NUM-1:0]    disp_oitf_qubitlist
);
  localparam int PLD_W = $bits(alu_pld_t);

  logic     w_is_lsu, w_longpipe, w_dep, w_res_ok, w_slot_free, w_fire;
  logic     w_vld_q, w_vld_ld;
  alu_pld_t w_pld_d, w_pld_q;

  assign w_is_lsu   = is_grp(disp_i_info, GRP_LSU);
  assign w_longpipe = w_is_lsu | disp_i_measure;

  // x0 sources never alias an in-flight write, so they cannot raise a hazard
  assign w_dep = (disp_i_rs1en & ~disp_i_rs1x0 & oitfrd_match_disprs1)
               | (disp_i_rs2en & ~disp_i_rs2x0 & oitfrd_match_disprs2)
               | (disp_i_rdwen & oitfrd_match_disprd)
               | ((disp_i_nqf | disp_i_fmr) & oitfqf_match_dispql);

  assign w_res_ok    = (~w_is_lsu | disp_oitf_ready) & (~disp_i_measure | disp_moitf_ready);
  assign w_slot_free = ~w_vld_q | disp_o_alu_ready;

  // Ready does not look at valid so upstream can use it without a loop
  assign disp_i_ready = ~w_dep & w_res_ok & w_slot_free;
  assign w_fire       = disp_i_valid & disp_i_ready;

  assign disp_oitf_ena       = w_fire & w_is_lsu;
  assign disp_moitf_ena      = w_fire & disp_i_measure;
  assign disp_oitf_rs1en     = disp_i_rs1en;
  assign disp_oitf_rs2en     = disp_i_rs2en;
  assign disp_oitf_rdwen     = disp_i_rdwen;
  assign disp_oitf_rs1idx    = disp_i_rs1idx;
  assign disp_oitf_rs2idx    = disp_i_rs2idx;
  assign disp_oitf_rdidx     = disp_i_rdidx;
  assign disp_oitf_qfren     = disp_i_nqf | disp_i_measure;
  assign disp_oitf_qubitlist = disp_i_imm[QUBIT_NUM-1:0];

  // Slot valid: reload on fire, drop on consume; fire wins so consume+fire keeps it full
  assign w_vld_ld = w_fire | (w_vld_q & disp_o_alu_ready);

  qpu_gnrl_dfflr #(.DW(1)) u_vld (
    .clk(clk), .rst_n(rst_n), .i_lden(w_vld_ld), .i_dnxt(w_fire), .o_qout(w_vld_q)
  );

  // Payload mux: zero the operand of an x0 source
  always_comb begin
    w_pld_d          = '0;
    w_pld_d.longpipe = w_longpipe;
    w_pld_d.rs1      = disp_i_rs1x0 ? '0 : disp_i_rs1;
    w_pld_d.rs2      = disp_i_rs2x0 ? '0 : disp_i_rs2;
    w_pld_d.rdwen    = disp_i_rdwen;
    w_pld_d.rdidx    = disp_i_rdidx;
    w_pld_d.info     = disp_i_info;
    w_pld_d.imm      = disp_i_imm;
    w_pld_d.pc       = disp_i_pc;
    w_pld_d.clk      = disp_i_clk;
    w_pld_d.qmr      = disp_i_qmr;
    w_pld_d.edata    = disp_i_edata;
    w_pld_d.oprand   = disp_i_oprand;
    w_pld_d.tqgl_pre = disp_i_tqgl_pre;
    w_pld_d.tqgl_cur = disp_i_tqgl_cur;
    w_pld_d.ntp      = disp_i_ntp;
    w_pld_d.fmr      = disp_i_fmr;
    w_pld_d.measure  = disp_i_measure;
  end

  // Payload only moves on fire, so it is frozen while the ALU back-pressures
  qpu_gnrl_dfflr #(.DW(PLD_W)) u_pld (
    .clk(clk), .rst_n(rst_n), .i_lden(w_fire), .i_dnxt(w_pld_d), .o_qout(w_pld_q)
  );

  assign disp_o_alu_valid    = w_vld_q;
  assign disp_o_alu_longpipe = w_pld_q.longpipe;
  assign disp_o_alu_rs1      = w_pld_q.rs1;
  assign disp_o_alu_rs2      = w_pld_q.rs2;
  assign disp_o_alu_rdwen    = w_pld_q.rdwen;
  assign disp_o_alu_rdidx    = w_pld_q.rdidx;
  assign disp_o_alu_info     = w_pld_q.info;
  assign disp_o_alu_imm      = w_pld_q.imm;
  assign disp_o_alu_pc       = w_pld_q.pc;
  assign disp_o_alu_clk      = w_pld_q.clk;
  assign disp_o_alu_qmr      = w_pld_q.qmr;
  assign disp_o_alu_edata    = w_pld_q.edata;
  assign disp_o_alu_oprand   = w_pld_q.oprand;
  assign disp_o_alu_tqgl_pre = w_pld_q.tqgl_pre;
  assign disp_o_alu_tqgl_cur = w_pld_q.tqgl_cur;
  assign disp_o_alu_ntp      = w_pld_q.ntp;
  assign disp_o_alu_fmr      = w_pld_q.fmr;
  assign disp_o_alu_measure  = w_pld_q.measure;
endmodule

// File: tb/tb_qpu_exu_dispatch.sv
// Directed + random bench for qpu_exu_dispatch against a transaction-level model.
module tb_qpu_exu_dispatch;
  import qpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                    disp_i_valid, disp_i_ready;
  logic                    disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en, disp_i_rdwen;
  logic                    disp_i_ntp, disp_i_measure, disp_i_nqf, disp_i_fmr;
  logic [RFIDX_W-1:0]      disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic [XLEN-1:0]         disp_i_rs1, disp_i_rs2, disp_i_imm;
  logic [DECINFO_W-1:0]    disp_i_info;
  logic [PC_W-1:0]         disp_i_pc;
  logic [TIME_W-1:0]       disp_i_clk;
  logic [QUBIT_NUM-1:0]    disp_i_qmr;
  logic [EVENT_WIRE_W-1:0] disp_i_edata;
  logic [EVENT_NUM-1:0]    disp_i_oprand;
  logic [TQGL_W-1:0]       disp_i_tqgl_pre, disp_i_tqgl_cur;
  logic                    disp_o_alu_valid, disp_o_alu_ready, disp_o_alu_longpipe;
  logic [XLEN-1:0]         disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_imm;
  logic                    disp_o_alu_rdwen;
  logic [RFIDX_W-1:0]      disp_o_alu_rdidx;
  logic [DECINFO_W-1:0]    disp_o_alu_info;
  logic [PC_W-1:0]         disp_o_alu_pc;
  logic [TIME_W-1:0]       disp_o_alu_clk;
  logic [QUBIT_NUM-1:0]    disp_o_alu_qmr;
  logic [EVENT_WIRE_W-1:0] disp_o_alu_edata;
  logic [EVENT_NUM-1:0]    disp_o_alu_oprand;
  logic [TQGL_W-1:0]       disp_o_alu_tqgl_pre, disp_o_alu_tqgl_cur;
  logic                    disp_o_alu_ntp, disp_o_alu_fmr, disp_o_alu_measure;
  logic                    oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql;
  logic                    disp_oitf_ena, disp_moitf_ena, disp_oitf_ready, disp_moitf_ready;
  logic                    disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen, disp_oitf_qfren;
  logic [RFIDX_W-1:0]      disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx;
  logic [QUBIT_NUM-1:0]    disp_oitf_qubitlist;

  qpu_exu_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready),
    .disp_i_rs1x0(disp_i_rs1x0), .disp_i_rs2x0(disp_i_rs2x0),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rdwen(disp_i_rdwen),
    .disp_i_ntp(disp_i_ntp), .disp_i_measure(disp_i_measure), .disp_i_nqf(disp_i_nqf), .disp_i_fmr(disp_i_fmr),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rdidx(disp_i_rdidx),
    .disp_i_rs1(disp_i_rs1), .disp_i_rs2(disp_i_rs2), .disp_i_imm(disp_i_imm),
    .disp_i_info(disp_i_info), .disp_i_pc(disp_i_pc), .disp_i_clk(disp_i_clk), .disp_i_qmr(disp_i_qmr),
    .disp_i_edata(disp_i_edata), .disp_i_oprand(disp_i_oprand),
    .disp_i_tqgl_pre(disp_i_tqgl_pre), .disp_i_tqgl_cur(disp_i_tqgl_cur),
    .disp_o_alu_valid(disp_o_alu_valid), .disp_o_alu_ready(disp_o_alu_ready),
    .disp_o_alu_longpipe(disp_o_alu_longpipe),
    .disp_o_alu_rs1(disp_o_alu_rs1), .disp_o_alu_rs2(disp_o_alu_rs2),
    .disp_o_alu_rdwen(disp_o_alu_rdwen), .disp_o_alu_rdidx(disp_o_alu_rdidx),
    .disp_o_alu_info(disp_o_alu_info), .disp_o_alu_imm(disp_o_alu_imm), .disp_o_alu_pc(disp_o_alu_pc),
    .disp_o_alu_clk(disp_o_alu_clk), .disp_o_alu_qmr(disp_o_alu_qmr),
    .disp_o_alu_edata(disp_o_alu_edata), .disp_o_alu_oprand(disp_o_alu_oprand),
    .disp_o_alu_tqgl_pre(disp_o_alu_tqgl_pre), .disp_o_alu_tqgl_cur(disp_o_alu_tqgl_cur),
    .disp_o_alu_ntp(disp_o_alu_ntp), .disp_o_alu_fmr(disp_o_alu_fmr), .disp_o_alu_measure(disp_o_alu_measure),
    .oitfrd_match_disprs1(oitfrd_match_disprs1), .oitfrd_match_disprs2(oitfrd_match_disprs2),
    .oitfrd_match_disprd(oitfrd_match_disprd), .oitfqf_match_dispql(oitfqf_match_dispql),
    .disp_oitf_ena(disp_oitf_ena), .disp_moitf_ena(disp_moitf_ena),
    .disp_oitf_ready(disp_oitf_ready), .disp_moitf_ready(disp_moitf_ready),
    .disp_oitf_rs1en(disp_oitf_rs1en), .disp_oitf_rs2en(disp_oitf_rs2en),
    .disp_oitf_rdwen(disp_oitf_rdwen), .disp_oitf_qfren(disp_oitf_qfren),
    .disp_oitf_rs1idx(disp_oitf_rs1idx), .disp_oitf_rs2idx(disp_oitf_rs2idx),
    .disp_oitf_rdidx(disp_oitf_rdidx), .disp_oitf_qubitlist(disp_oitf_qubitlist)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what the ALU side should be holding
  logic     m_valid;
  alu_pld_t m_pld;

  // Observed combinational values of the last cycle, for directed checks
  logic s_rdy, s_ena, s_mena;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_grp(input grp_e g);
    disp_i_info = 16'(($urandom() << GRP_W) | 32'(g));
  endtask

  task automatic clear_inputs();
    disp_i_valid = 0; disp_i_rs1x0 = 0; disp_i_rs2x0 = 0; disp_i_rs1en = 0; disp_i_rs2en = 0;
    disp_i_rdwen = 0; disp_i_ntp = 0; disp_i_measure = 0; disp_i_nqf = 0; disp_i_fmr = 0;
    disp_i_rs1idx = 5'd1; disp_i_rs2idx = 5'd2; disp_i_rdidx = 5'd3;
    disp_i_rs1 = 0; disp_i_rs2 = 0; disp_i_imm = 0; disp_i_info = 0; disp_i_pc = 32'h100;
    disp_i_clk = 0; disp_i_qmr = 0; disp_i_edata = 0; disp_i_oprand = 0;
    disp_i_tqgl_pre = 0; disp_i_tqgl_cur = 0;
    oitfrd_match_disprs1 = 0; oitfrd_match_disprs2 = 0; oitfrd_match_disprd = 0; oitfqf_match_dispql = 0;
    disp_oitf_ready = 1; disp_moitf_ready = 1; disp_o_alu_ready = 1;
  endtask

  task automatic rand_inputs();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    disp_i_valid   = ($urandom_range(3) != 0);
    disp_i_rs1x0   = ($urandom_range(3) == 0);
    disp_i_rs2x0   = ($urandom_range(3) == 0);
    disp_i_rs1en   = r[0]; disp_i_rs2en = r[1]; disp_i_rdwen = r[2]; disp_i_ntp = r[3];
    disp_i_measure = ($urandom_range(3) == 0);
    disp_i_nqf     = r[4]; disp_i_fmr = r[5];
    disp_i_rs1idx  = r[10:6]; disp_i_rs2idx = r[15:11]; disp_i_rdidx = r[20:16];
    disp_i_qmr     = r[24:21]; disp_i_oprand = r[32:25];
    disp_i_rs1     = $urandom(); disp_i_rs2 = $urandom(); disp_i_imm = $urandom();
    disp_i_pc      = $urandom(); disp_i_clk = $urandom();
    disp_i_edata   = r[98:33];
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    disp_i_tqgl_pre = r[47:0]; disp_i_tqgl_cur = r[95:48];
    set_grp(grp_e'(3'($urandom_range(4))));
    oitfrd_match_disprs1 = ($urandom_range(3) == 0);
    oitfrd_match_disprs2 = ($urandom_range(3) == 0);
    oitfrd_match_disprd  = ($urandom_range(3) == 0);
    oitfqf_match_dispql  = ($urandom_range(3) == 0);
    disp_oitf_ready  = ($urandom_range(3) != 0);
    disp_moitf_ready = ($urandom_range(3) != 0);
    disp_o_alu_ready = ($urandom_range(3) != 0);
  endtask

  // One clock: called just after the falling edge with inputs applied
  task automatic cycle();
    logic lsu, hazard, rdy, fire;
    #1;
    lsu    = (disp_i_info[GRP_LSB +: GRP_W] == 3'(GRP_LSU));
    hazard = (disp_i_rs1en && !disp_i_rs1x0 && oitfrd_match_disprs1)
          || (disp_i_rs2en && !disp_i_rs2x0 && oitfrd_match_disprs2)
          || (disp_i_rdwen && oitfrd_match_disprd)
          || ((disp_i_nqf || disp_i_fmr) && oitfqf_match_dispql);
    rdy  = !hazard && (!lsu || disp_oitf_ready) && (!disp_i_measure || disp_moitf_ready)
        && (!m_valid || disp_o_alu_ready);
    fire = disp_i_valid && rdy;
    s_rdy = disp_i_ready; s_ena = disp_oitf_ena; s_mena = disp_moitf_ena;
    chk("i_ready",   128'(disp_i_ready),        128'(rdy));
    chk("oitf_ena",  128'(disp_oitf_ena),       128'(fire && lsu));
    chk("moitf_ena", 128'(disp_moitf_ena),      128'(fire && disp_i_measure));
    chk("qfren",     128'(disp_oitf_qfren),     128'(disp_i_nqf || disp_i_measure));
    chk("qubitlist", 128'(disp_oitf_qubitlist), 128'(disp_i_imm[QUBIT_NUM-1:0]));
    chk("oitf_rd",   128'({disp_oitf_rdwen, disp_oitf_rdidx, disp_oitf_rs1idx}),
                     128'({disp_i_rdwen, disp_i_rdidx, disp_i_rs1idx}));
    if (fire) begin
      m_pld.longpipe = lsu || disp_i_measure;
      m_pld.rs1      = disp_i_rs1x0 ? 32'd0 : disp_i_rs1;
      m_pld.rs2      = disp_i_rs2x0 ? 32'd0 : disp_i_rs2;
      m_pld.rdwen    = disp_i_rdwen;   m_pld.rdidx    = disp_i_rdidx;
      m_pld.info     = disp_i_info;    m_pld.imm      = disp_i_imm;
      m_pld.pc       = disp_i_pc;      m_pld.clk      = disp_i_clk;
      m_pld.qmr      = disp_i_qmr;     m_pld.edata    = disp_i_edata;
      m_pld.oprand   = disp_i_oprand;  m_pld.tqgl_pre = disp_i_tqgl_pre;
      m_pld.tqgl_cur = disp_i_tqgl_cur; m_pld.ntp     = disp_i_ntp;
      m_pld.fmr      = disp_i_fmr;     m_pld.measure  = disp_i_measure;
    end
    @(posedge clk); #1;
    if (fire) m_valid = 1'b1;
    else if (m_valid && disp_o_alu_ready) m_valid = 1'b0;
    chk("alu_valid", 128'(disp_o_alu_valid), 128'(m_valid));
    chk("alu_rs",    128'({disp_o_alu_rs1, disp_o_alu_rs2}), 128'({m_pld.rs1, m_pld.rs2}));
    chk("alu_misc",  128'({disp_o_alu_longpipe, disp_o_alu_measure, disp_o_alu_fmr, disp_o_alu_ntp,
                           disp_o_alu_rdwen, disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_qmr, disp_o_alu_oprand}),
                     128'({m_pld.longpipe, m_pld.measure, m_pld.fmr, m_pld.ntp,
                           m_pld.rdwen, m_pld.rdidx, m_pld.info, m_pld.qmr, m_pld.oprand}));
    chk("alu_imm_pc", 128'({disp_o_alu_imm, disp_o_alu_pc, disp_o_alu_clk}),
                      128'({m_pld.imm, m_pld.pc, m_pld.clk}));
    chk("alu_edata", 128'(disp_o_alu_edata), 128'(m_pld.edata));
    chk("alu_tqgl",  128'({disp_o_alu_tqgl_pre, disp_o_alu_tqgl_cur}),
                     128'({m_pld.tqgl_pre, m_pld.tqgl_cur}));
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    m_valid = 1'b0; m_pld = '0;
    rst_n = 1'b0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",    128'(disp_o_alu_valid),    128'(0));
    chk("rst_rs1",      128'(disp_o_alu_rs1),      128'(0));
    chk("rst_longpipe", 128'(disp_o_alu_longpipe), 128'(0));
    chk("rst_oitf_ena", 128'(disp_oitf_ena),       128'(0));
    chk("rst_moitf",    128'(disp_moitf_ena),      128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // ADD, no hazards
    set_grp(GRP_ALU);
    disp_i_valid = 1; disp_i_rs1en = 1; disp_i_rs2en = 1; disp_i_rs1 = 5; disp_i_rs2 = 7;
    cycle();
    chk("add_rdy",      128'(s_rdy),               128'(1));
    chk("add_rs1",      128'(disp_o_alu_rs1),      128'(5));
    chk("add_rs2",      128'(disp_o_alu_rs2),      128'(7));
    chk("add_longpipe", 128'(disp_o_alu_longpipe), 128'(0));
    disp_i_rs1x0 = 1; disp_i_rs1 = 9;
    cycle();
    chk("x0_rs1",       128'(disp_o_alu_rs1),      128'(0));
    disp_i_rs1x0 = 0;

    // RAW hazard on rs1 stalls, then clears
    oitfrd_match_disprs1 = 1; disp_i_rs1 = 32'h11;
    cycle();
    chk("haz_rdy",   128'(s_rdy),            128'(0));
    chk("haz_nocap", 128'(disp_o_alu_valid), 128'(0));
    oitfrd_match_disprs1 = 0;
    cycle();
    chk("haz_go",    128'(disp_o_alu_rs1),   128'(32'h11));

    // LOAD waits on OITF space, allocates once
    set_grp(GRP_LSU); disp_oitf_ready = 0; disp_i_rs1 = 32'h20;
    cycle();
    chk("ld_stall",  128'(s_rdy), 128'(0));
    disp_oitf_ready = 1;
    cycle();
    chk("ld_ena",      128'(s_ena),               128'(1));
    chk("ld_longpipe", 128'(disp_o_alu_longpipe), 128'(1));
    disp_i_valid = 0;
    cycle();
    chk("ld_ena_off",  128'(s_ena),               128'(0));

    // Measure allocates in the measure OITF
    set_grp(GRP_ALU); disp_i_valid = 1; disp_i_measure = 1; disp_i_imm = 32'h2;
    cycle();
    chk("ms_mena",  128'(s_mena),               128'(1));
    chk("ms_qlist", 128'(disp_o_alu_imm[QUBIT_NUM-1:0]), 128'(4'b0010));
    chk("ms_lp",    128'(disp_o_alu_longpipe),  128'(1));
    disp_i_measure = 0;
    // Quantum op blocked by qubit-flag hazard
    set_grp(GRP_QIU); disp_i_nqf = 1; oitfqf_match_dispql = 1;
    cycle();
    chk("qi_stall", 128'(s_rdy), 128'(0));
    disp_i_nqf = 0; oitfqf_match_dispql = 0;

    // Back-pressure holds the slot, then a back-to-back transfer
    set_grp(GRP_ALU); disp_i_rs1 = 32'hA5A5; disp_o_alu_ready = 1;
    cycle();
    disp_o_alu_ready = 0; disp_i_rs1 = 32'h5A5A;
    cycle();
    chk("bp_rdy",  128'(s_rdy),          128'(0));
    cycle();
    chk("bp_hold", 128'(disp_o_alu_rs1), 128'(32'hA5A5));
    disp_o_alu_ready = 1;
    cycle();
    chk("b2b_rdy",   128'(s_rdy),            128'(1));
    chk("b2b_valid", 128'(disp_o_alu_valid), 128'(1));
    chk("b2b_rs1",   128'(disp_o_alu_rs1),   128'(32'h5A5A));

    // Reset in the middle of a held transfer drops it
    disp_o_alu_ready = 0;
    cycle();
    disp_i_valid = 0;
    rst_n = 1'b0; #1;
    m_valid = 1'b0; m_pld = '0;
    chk("mid_rst_valid", 128'(disp_o_alu_valid), 128'(0));
    chk("mid_rst_rs1",   128'(disp_o_alu_rs1),   128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    disp_o_alu_ready = 1;
    cycle();
    chk("post_rst_valid", 128'(disp_o_alu_valid), 128'(0));

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qpu_exu_dispatch.md
QPU_EXU_DISPATCH -- requirements
Module: qpu_exu_dispatch

Interface
REQ-001 Parameters: none; all widths come from shared package constants (XLEN, RFIDX_W, DECINFO_W, PC_W, TIME_W, QUBIT_NUM, EVENT_WIRE_W=66, EVENT_NUM=8, TQGL_W=48).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 disp_i_valid  in  1 / disp_i_ready  out  1  decode-to-dispatch handshake.
REQ-005 disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en, disp_i_rdwen, disp_i_ntp, disp_i_measure, disp_i_nqf, disp_i_fmr  in  1 each  decoded flags.
REQ-006 disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx  in  RFIDX_W; disp_i_rs1, disp_i_rs2, disp_i_imm  in  XLEN; disp_i_info  in  DECINFO_W; disp_i_pc  in  PC_W.
REQ-007 disp_i_clk  in  TIME_W; disp_i_qmr  in  QUBIT_NUM; disp_i_edata  in  66; disp_i_oprand  in  8; disp_i_tqgl_pre, disp_i_tqgl_cur  in  48.
REQ-008 disp_o_alu_valid  out  1 / disp_o_alu_ready  in  1  ALU handshake; disp_o_alu_longpipe  out  1.
REQ-009 disp_o_alu_{rs1,rs2,rdwen,rdidx,info,imm,pc,clk,qmr,edata,oprand,tqgl_pre,tqgl_cur,ntp,fmr,measure}  out  same widths as the matching inputs  registered payload.
REQ-010 oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql  in  1  OITF hazard hits.
REQ-011 disp_oitf_ena, disp_moitf_ena  out  1  allocation strobes; disp_oitf_ready, disp_moitf_ready  in  1  FIFO-not-full indications.
REQ-012 disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen, disp_oitf_qfren  out  1; disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx  out  RFIDX_W; disp_oitf_qubitlist  out  QUBIT_NUM.

Function
REQ-013 is_lsu SHALL be true when disp_i_info[GRP field] equals the package constant GRP_LSU; longpipe = is_lsu | disp_i_measure.
REQ-014 dep = (rs1en & ~rs1x0 & match_rs1) | (rs2en & ~rs2x0 & match_rs2) | (rdwen & match_rd) | ((nqf | fmr) & oitfqf_match_dispql).
REQ-015 res_ok = (~is_lsu | disp_oitf_ready) & (~measure | disp_moitf_ready); slot_free = ~disp_o_alu_valid | disp_o_alu_ready.
REQ-016 disp_i_ready = ~dep & res_ok & slot_free, combinational and independent of disp_i_valid; fire = disp_i_valid & disp_i_ready.
REQ-017 disp_oitf_ena = fire & is_lsu; disp_moitf_ena = fire & disp_i_measure; each SHALL pulse for exactly one cycle per instruction.
REQ-018 disp_oitf_rs1en/rs2en/rdwen/idx pass through combinationally; disp_oitf_qfren = nqf | measure; disp_oitf_qubitlist = disp_i_imm[QUBIT_NUM-1:0].
REQ-019 On fire, the payload register captures all inputs, with rs1 forced to 0 when rs1x0 and rs2 forced to 0 when rs2x0; longpipe is captured too. Latency is one cycle.
REQ-020 disp_o_alu_valid: set on fire; cleared when valid & disp_o_alu_ready & ~fire; otherwise held. Payload SHALL stay stable while valid & ~ready.
REQ-021 Simultaneous consume and fire SHALL load the new instruction with valid remaining 1 (no bubble).

Reset
REQ-022 While rst_n=0: disp_o_alu_valid=0 and all registered payload outputs (including longpipe) = 0. Combinational outputs follow REQ-016..018.
REQ-023 Reset asserted mid-transfer SHALL drop the in-flight instruction; no allocation strobe is generated for it.

Structure
REQ-024 The shared package qpu_pkg SHALL hold the widths, the DECINFO GRP field position and the GRP_* encodings.
REQ-025 A single sub-module, qpu_gnrl_dfflr (load-enable flop with async active-low reset), SHALL implement the valid and payload registers.

Verification
REQ-026 rst_n=0 -> disp_o_alu_valid=0, disp_o_alu_rs1=0, disp_oitf_ena=0, disp_moitf_ena=0.
REQ-027 ADD, rs1=5, rs2=7, no hazards, alu_ready=1 -> disp_i_ready=1; next edge valid=1, rs1=5, rs2=7, longpipe=0; with rs1x0=1 -> rs1=0.
REQ-028 rs1en=1 and match_rs1=1 -> disp_i_ready=0 and no capture; drop the match -> dispatch on the next edge.
REQ-029 LOAD with disp_oitf_ready=0 -> stall; raise ready -> disp_oitf_ena=1 for one cycle, then longpipe=1.
REQ-030 measure with imm=2'b10, moitf_ready=1 -> disp_moitf_ena=1, qfren=1, qubitlist=...10; QI with nqf=1 and qf match=1 -> stall.
REQ-031 alu_ready=0 while valid=1 -> payload held bit-stable and disp_i_ready=0; ready=1 with a new valid input -> back-to-back transfer.
